// File: rtl/rng_address_requester.sv
// Initiator for the start/done rng_address handshake: draws a value from a
// Galois LFSR, hands it with the modulus to the responder and captures the result.
module rng_address_requester #(
    parameter logic [15:0] LFSR_INIT      = 16'hACE1,
    parameter int unsigned TIMEOUT_CYCLES = 131071
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] neighbor_count,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [15:0] which,
    output logic [15:0] betterNeighborCount,
    output logic        start_rng_address,
    input  logic        done_rng_address,
    input  logic [15:0] rng_address,
    output logic [15:0] address,
    output logic        address_valid,
    output logic        timeout_err,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TAPS     = 16'hB400;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] which_d;
    logic [15:0] bnc_d;
    logic [15:0] addr_d;
    logic        valid_d;
    logic        terr_d;
    logic [16:0] cnt_q;
    logic [16:0] cnt_d;
    logic        resp_q;
    logic        resp_rise;
    logic [15:0] seeded;
    logic [15:0] stepped;

    // A same-cycle seed load feeds the step, so seed+req draws from the new seed
    assign seeded    = !seed_load ? lfsr_q :
                       (seed == 16'h0000) ? LFSR_INIT : seed;
    assign stepped   = {1'b0, seeded[15:1]} ^ (seeded[0] ? TAPS : 16'h0000);
    assign resp_rise = done_rng_address && !resp_q;

    assign start_rng_address = (state_q == ISSUE);
    assign done              = (state_q == DONE);
    assign busy              = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        which_d = which;
        bnc_d   = betterNeighborCount;
        addr_d  = address;
        valid_d = address_valid;
        terr_d  = timeout_err;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = seeded;
                end
                if (req) begin
                    valid_d = 1'b0;
                    terr_d  = 1'b0;
                    if (neighbor_count == 16'h0000) begin
                        addr_d  = 16'h0000;
                        state_d = DONE;
                    end else begin
                        lfsr_d  = stepped;
                        which_d = stepped;
                        bnc_d   = neighbor_count;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 17'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // A stale high level from the responder never counts as an answer
                if (resp_rise) begin
                    addr_d  = rng_address;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b0;
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q             <= IDLE;
            lfsr_q              <= LFSR_INIT;
            which               <= 16'h0000;
            betterNeighborCount <= 16'h0000;
            address             <= 16'h0000;
            address_valid       <= 1'b0;
            timeout_err         <= 1'b0;
            cnt_q               <= 17'd0;
            resp_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            lfsr_q              <= lfsr_d;
            which               <= which_d;
            betterNeighborCount <= bnc_d;
            address             <= addr_d;
            address_valid       <= valid_d;
            timeout_err         <= terr_d;
            cnt_q               <= cnt_d;
            resp_q              <= done_rng_address;
        end
    end

endmodule

// File: tb/tb_rng_address_requester.sv
// Directed bench for rng_address_requester: hand-computed LFSR draws,
// zero modulus, stale responder level, timeout and reset mid-transaction.
module tb_rng_address_requester;

    logic        clock = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] neighbor_count;
    logic        seed_load;
    logic [15:0] seed;
    logic [15:0] which;
    logic [15:0] betterNeighborCount;
    logic        start_rng_address;
    logic        done_rng_address;
    logic [15:0] rng_address;
    logic [15:0] address;
    logic        address_valid;
    logic        timeout_err;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_done  = 0;

    rng_address_requester #(
        .LFSR_INIT     (16'hACE1),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clock              (clock),
        .rst                (rst),
        .req                (req),
        .neighbor_count     (neighbor_count),
        .seed_load          (seed_load),
        .seed               (seed),
        .which              (which),
        .betterNeighborCount(betterNeighborCount),
        .start_rng_address  (start_rng_address),
        .done_rng_address   (done_rng_address),
        .rng_address        (rng_address),
        .address            (address),
        .address_valid      (address_valid),
        .timeout_err        (timeout_err),
        .done               (done),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (start_rng_address) n_start++;
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Modulo responder: answers with a clean rising edge after dly cycles
    task automatic respond(input int dly);
        repeat (dly) tick();
        rng_address      = which % betterNeighborCount;
        done_rng_address = 1'b1;
        tick();
        done_rng_address = 1'b0;
    endtask

    task automatic request(input logic [15:0] cnt);
        req            = 1'b1;
        neighbor_count = cnt;
        tick();
        req            = 1'b0;
        neighbor_count = 16'h0000;
    endtask

    int s0;
    int d0;
    int wcyc;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        neighbor_count = 16'h0000;
        seed_load = 1'b0;
        seed = 16'h0000;
        done_rng_address = 1'b0;
        rng_address = 16'h0000;
        tick();
        tick();
        chk("rst_outs", {which, betterNeighborCount, address},
            32'h0);
        chk("rst_flags", {28'h0, start_rng_address, address_valid,
            timeout_err, done | busy}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: first draw from ACE1 is E270, 57968 % 5 = 3
        s0 = n_start;
        request(16'd5);
        chk("t1_start", start_rng_address, 1);
        chk("t1_which", which, 16'hE270);
        chk("t1_bnc", betterNeighborCount, 16'd5);
        respond(2);
        chk("t1_done", done, 1);
        chk("t1_addr", address, 16'd3);
        chk("t1_valid", address_valid, 1);
        chk("t1_nstart", n_start - s0, 1);
        tick();
        chk("t1_idle", {done, busy}, 2'b00);
        chk("t1_hold", {address_valid, address}, {1'b1, 16'd3});

        // 2: zero seed reloads ACE1, so draw repeats E270, 57968 % 7 = 1
        seed_load = 1'b1;
        seed = 16'h0000;
        tick();
        seed_load = 1'b0;
        request(16'd7);
        chk("t2_which", which, 16'hE270);
        tick();
        respond(1);
        chk("t2_addr", address, 16'd1);

        // 3: zero modulus finishes one cycle later without a start
        tick();
        s0 = n_start;
        request(16'd0);
        chk("t3_done", done, 1);
        chk("t3_flags", {address_valid, timeout_err}, 2'b00);
        chk("t3_addr", address, 16'd0);
        tick();
        chk("t3_nstart", n_start - s0, 0);

        // 4: stale high level ignored; E270 -> 7138, 28984 % 9 = 4
        done_rng_address = 1'b1;
        rng_address = 16'hDEAD;
        tick();
        request(16'd9);
        chk("t4_which", which, 16'h7138);
        tick();
        repeat (3) tick();
        chk("t4_stale", {busy, done}, 2'b10);
        done_rng_address = 1'b0;
        repeat (7) tick();
        chk("t4_wait", {busy, done}, 2'b10);
        respond(0);
        chk("t4_done", done, 1);
        chk("t4_addr", address, 16'd4);
        chk("t4_valid", address_valid, 1);
        tick();

        // 5: silent responder; 7138 -> 389C, abort after 20 WAIT cycles
        request(16'd100);
        chk("t5_which", which, 16'h389C);
        wcyc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) break;
            if (busy && !start_rng_address) wcyc++;
        end
        chk("t5_wcyc", wcyc, 20);
        chk("t5_done", done, 1);
        chk("t5_terr", timeout_err, 1);
        chk("t5_valid", address_valid, 0);
        tick();

        // 6: busy req ignored, reset in WAIT drops the transaction
        s0 = n_start;
        d0 = n_done;
        request(16'd3);
        chk("t6_which", which, 16'h1C4E);
        tick();
        req = 1'b1;
        neighbor_count = 16'd2;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_outs", {which, betterNeighborCount}, 32'h0);
        chk("t6_addr", address, 16'h0);
        chk("t6_flags", {address_valid, timeout_err, start_rng_address,
            done, busy}, 5'b0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_nstart", n_start - s0, 1);
        chk("t6_ndone", n_done - d0, 0);
        request(16'd5);
        chk("t6_relfsr", which, 16'hE270);
        tick();
        respond(1);
        chk("t6_addr2", address, 16'd3);
        tick();

        // 7: seed 1 with req same cycle steps from the seed -> B400
        seed_load = 1'b1;
        seed = 16'h0001;
        request(16'd10);
        seed_load = 1'b0;
        chk("t7_which", which, 16'hB400);
        tick();
        respond(1);
        chk("t7_addr", {address_valid, address}, {1'b1, 16'd0});
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
